axi_rd: RTL and testbench
=========================

AXI_RD -- requirements
Module: axi_rd

Interface
REQ-001 SHALL have parameter D_BYTES_PER_LINE, default 16, cache line size in bytes.
REQ-002 SHALL have parameter D_WORDS_PER_LINE, default D_BYTES_PER_LINE/4; D_LINE_WIDTH = D_WORDS_PER_LINE*32.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rd_req  in  1  read request from cache; accepted when rd_rdy=1.
REQ-006 SHALL have port rd_rdy  out  1  block can accept a request.
REQ-007 SHALL have port burst  in  1  1 = line refill (INCR burst), 0 = single uncached access.
REQ-008 SHALL have port addr  in  32  request address.
REQ-009 SHALL have port size  in  2  log2 bytes for single access.
REQ-010 SHALL have port rd_valid  out  1  one-cycle pulse: rd_data complete.
REQ-011 SHALL have port rd_data  out  D_LINE_WIDTH  assembled line; single access in bits [31:0].
REQ-012 SHALL have port wr_idle  in  1  write channel buffer empty.
REQ-013 SHALL have port read_unfinish  out  1  AR/R transaction outstanding; blocks writer.
REQ-014 SHALL have ports arid/arlock/arcache/arprot  out  4/2/4/3  constant zero.
REQ-015 SHALL have port araddr  out  32  read address.
REQ-016 SHALL have port arlen  out  8  burst length minus one.
REQ-017 SHALL have port arsize  out  3  beat size.
REQ-018 SHALL have port arburst  out  2  burst type.
REQ-019 SHALL have ports arvalid out 1 / arready in 1  AR handshake.
REQ-020 SHALL have ports rid in 4, rresp in 2  accepted and ignored.
REQ-021 SHALL have ports rdata in 32, rlast in 1, rvalid in 1, rready out 1  R channel.

Function
REQ-022 SHALL implement states IDLE, WAIT_WR, AR, R, DONE.
REQ-023 SHALL assert rd_rdy only in IDLE; rd_req & rd_rdy latches addr, burst, size, clears word pointer, goes WAIT_WR.
REQ-024 SHALL leave WAIT_WR for AR on the first cycle with wr_idle=1 (at least one cycle in WAIT_WR, so a same-cycle wr_req is drained first).
REQ-025 SHALL assert arvalid only in AR; arvalid & arready moves to R; arvalid held with stable payload until arready.
REQ-026 SHALL drive, for burst: araddr = latched addr with low log2(D_BYTES_PER_LINE) bits zeroed, arlen = D_WORDS_PER_LINE-1, arsize = 3'b010, arburst = 2'b01.
REQ-027 SHALL drive, for single: araddr = latched addr unmodified, arlen = 0, arsize = {1'b0,size}, arburst = 2'b00.
REQ-028 SHALL assert rready only in R; each rvalid & rready beat writes rdata into rd_data word[pointer] and increments pointer (wraps at D_WORDS_PER_LINE).
REQ-029 SHALL move R to DONE on the beat with rlast=1; beats ignored when rready=0.
REQ-030 SHALL assert rd_valid for exactly the DONE cycle, then return to IDLE; rd_data held stable until next accepted request's first beat.
REQ-031 SHALL assert read_unfinish exactly in AR and R (deasserted in WAIT_WR, avoiding deadlock with the writer).
REQ-032 SHALL leave rd_data words not written by a single access unchanged.
REQ-033 SHALL ignore rd_req outside IDLE.

Reset
REQ-034 SHALL, on reset assertion (asynchronously, also mid-transaction), enter IDLE with rd_rdy=1, arvalid=0, rready=0, rd_valid=0, read_unfinish=0, pointer=0; rd_data undefined.
REQ-035 SHALL abandon any outstanding transaction on reset; no beats accepted until a new request.

Verification
REQ-036 SHALL test burst: rd_req, addr=0x1000_0014, wr_idle=1, arready=1, 4 beats 0xA0..0xA3 -> araddr=0x1000_0010, arlen=3, arsize=2, arburst=1, rd_data={A3,A2,A1,A0}, rd_valid one cycle.
REQ-037 SHALL test single: burst=0, addr=0xBFD0_0003, size=0 -> araddr=0xBFD0_0003, arlen=0, arsize=0, arburst=0, rd_data[31:0]=rdata, others unchanged.
REQ-038 SHALL test wr_idle=0 for 5 cycles -> stay WAIT_WR, arvalid=0, read_unfinish=0; AR one cycle after wr_idle rises.
REQ-039 SHALL test arready low 3 cycles and rvalid gaps between beats -> araddr stable, words stored in order, no lost or duplicate beat.
REQ-040 SHALL test reset asserted after 2 of 4 beats -> immediate IDLE, rready=0, read_unfinish=0; next request completes normally.

Source files
------------

// File: rtl/axi_rd_if.sv
// rtl/axi_rd_if.sv - AXI read address / read data channel bundle
interface axi_rd_if;
    logic [3:0]  arid;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, arlock, arcache, arprot, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rresp, rdata, rlast, rvalid
    );

    modport slave (
        input  arid, arlock, arcache, arprot, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rresp, rdata, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd.sv
// rtl/axi_rd.sv - cache-side read request to AXI AR/R transaction converter
module axi_rd #(
    parameter int D_BYTES_PER_LINE = 16,
    parameter int D_WORDS_PER_LINE = D_BYTES_PER_LINE / 4,
    localparam int D_LINE_WIDTH    = D_WORDS_PER_LINE * 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_req,
    output logic                    rd_rdy,
    input  logic                    burst,
    input  logic [31:0]             addr,
    input  logic [1:0]              size,
    output logic                    rd_valid,
    output logic [D_LINE_WIDTH-1:0] rd_data,
    input  logic                    wr_idle,
    output logic                    read_unfinish,
    axi_rd_if.master                axi
);

    localparam int PTR_W = (D_WORDS_PER_LINE > 1) ? $clog2(D_WORDS_PER_LINE) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_WR, AR, R, DONE} state_t;

    state_t             state;
    state_t             state_n;
    logic [31:0]        addr_q;
    logic               burst_q;
    logic [1:0]         size_q;
    logic [PTR_W-1:0]   ptr;
    logic               accept;
    logic               beat;

    // rid/rresp carry nothing this block acts on
    logic unused_r_fields;
    assign unused_r_fields = ^{axi.rid, axi.rresp};

    // AR payload comes straight from the latched request so it stays stable while arvalid waits
    assign axi.arid    = '0;
    assign axi.arlock  = '0;
    assign axi.arcache = '0;
    assign axi.arprot  = '0;
    assign axi.araddr  = burst_q ? (addr_q & ~32'(D_BYTES_PER_LINE - 1)) : addr_q;
    assign axi.arlen   = burst_q ? 8'(D_WORDS_PER_LINE - 1) : 8'd0;
    assign axi.arsize  = burst_q ? 3'b010 : {1'b0, size_q};
    assign axi.arburst = burst_q ? 2'b01 : 2'b00;

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and handshake outputs, all decoded from the current state
    always_comb begin
        state_n       = state;
        rd_rdy        = 1'b0;
        axi.arvalid   = 1'b0;
        axi.rready    = 1'b0;
        rd_valid      = 1'b0;
        read_unfinish = 1'b0;
        case (state)
            IDLE: begin
                rd_rdy = 1'b1;
                if (rd_req) state_n = WAIT_WR;
            end
            WAIT_WR: begin
                // Always spend one cycle here so a write issued alongside the read drains first
                if (wr_idle) state_n = AR;
            end
            AR: begin
                axi.arvalid   = 1'b1;
                read_unfinish = 1'b1;
                if (axi.arready) state_n = R;
            end
            R: begin
                axi.rready    = 1'b1;
                read_unfinish = 1'b1;
                if (axi.rvalid && axi.rlast) state_n = DONE;
            end
            DONE: begin
                rd_valid = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign accept = rd_rdy & rd_req;
    assign beat   = axi.rready & axi.rvalid;

    // Request latch and beat word pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            burst_q <= 1'b0;
            size_q  <= '0;
            ptr     <= '0;
        end else if (accept) begin
            addr_q  <= addr;
            burst_q <= burst;
            size_q  <= size;
            ptr     <= '0;
        end else if (beat) begin
            ptr <= (ptr == PTR_W'(D_WORDS_PER_LINE - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // Line assembly; words a transfer does not touch keep their previous contents
    always_ff @(posedge clk) begin
        if (beat) rd_data[ptr*32 +: 32] <= axi.rdata;
    end

endmodule

// File: tb/tb_axi_rd.sv
// tb/tb_axi_rd.sv - self-checking bench for axi_rd
module tb_axi_rd;
    localparam int BPL = 16;
    localparam int WPL = BPL / 4;
    localparam int LW  = WPL * 32;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_ADDR = 2;
    localparam int M_DATA = 3;
    localparam int M_DONE = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rd_req;
    logic          rd_rdy;
    logic          burst;
    logic [31:0]   addr;
    logic [1:0]    size;
    logic          rd_valid;
    logic [LW-1:0] rd_data;
    logic          wr_idle;
    logic          read_unfinish;

    int n_checks = 0;
    int n_pass   = 0;

    axi_rd_if axi ();

    axi_rd #(.D_BYTES_PER_LINE(BPL)) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_req        (rd_req),
        .rd_rdy        (rd_rdy),
        .burst         (burst),
        .addr          (addr),
        .size          (size),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .wr_idle       (wr_idle),
        .read_unfinish (read_unfinish),
        .axi           (axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // Reference model: transaction phase, latched request, expected line contents
    int          ph;
    logic [31:0] m_addr;
    logic        m_burst;
    logic [1:0]  m_size;
    int          m_ptr;
    logic [31:0] m_line [WPL];
    bit          m_known [WPL];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph    = M_IDLE;
            m_ptr = 0;
            for (int i = 0; i < WPL; i++) m_known[i] = 1'b0;
        end else begin
            case (ph)
                M_IDLE: if (rd_req) begin
                    m_addr = addr; m_burst = burst; m_size = size; m_ptr = 0; ph = M_WAIT;
                end
                M_WAIT: if (wr_idle) ph = M_ADDR;
                M_ADDR: if (axi.arready) ph = M_DATA;
                M_DATA: if (axi.rvalid) begin
                    m_line[m_ptr]  = axi.rdata;
                    m_known[m_ptr] = 1'b1;
                    m_ptr = (m_ptr + 1) % WPL;
                    if (axi.rlast) ph = M_DONE;
                end
                default: ph = M_IDLE;
            endcase
        end
    end

    // Compare every cycle, away from the rising edge
    always @(negedge clk) begin
        logic [31:0] ea;
        chk("rd_rdy", rd_rdy, ph == M_IDLE);
        chk("arvalid", axi.arvalid, ph == M_ADDR);
        chk("rready", axi.rready, ph == M_DATA);
        chk("rd_valid", rd_valid, ph == M_DONE);
        chk("read_unfinish", read_unfinish, (ph == M_ADDR) || (ph == M_DATA));
        chk("ar_consts", {axi.arid, axi.arlock, axi.arcache, axi.arprot}, 0);
        if (ph == M_ADDR) begin
            ea = m_burst ? (m_addr / BPL) * BPL : m_addr;
            chk("araddr", axi.araddr, ea);
            chk("arlen", axi.arlen, m_burst ? WPL - 1 : 0);
            chk("arsize", axi.arsize, m_burst ? 2 : m_size);
            chk("arburst", axi.arburst, m_burst ? 1 : 0);
        end
        for (int i = 0; i < WPL; i++)
            if (m_known[i]) chk($sformatf("rd_data_w%0d", i), rd_data[i*32 +: 32], m_line[i]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic b, input logic [31:0] a, input logic [1:0] s);
        int n = 0;
        while (!rd_rdy && n < 50) begin tick(); n++; end
        if (!rd_rdy) chk("req_timeout", 0, 1);
        rd_req = 1'b1; burst = b; addr = a; size = s;
        tick();
        rd_req = 1'b0; burst = ~b; addr = 32'hDEAD_BEEF; size = 2'd3;
    endtask

    task automatic do_ar(input int hold, output logic [31:0] ca, output logic [7:0] cl,
                         output logic [2:0] cs, output logic [1:0] cb);
        int n = 0;
        axi.arready = 1'b0;
        ca = '0; cl = '0; cs = '0; cb = '0;
        while (!axi.arvalid && n < 50) begin tick(); n++; end
        if (!axi.arvalid) begin
            chk("ar_timeout", 0, 1);
        end else begin
            ca = axi.araddr; cl = axi.arlen; cs = axi.arsize; cb = axi.arburst;
            repeat (hold) tick();
            axi.arready = 1'b1;
            tick();
            axi.arready = 1'b0;
        end
    endtask

    task automatic do_beats(input int n, input logic [31:0] base, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap) begin
                axi.rvalid = 1'b0; axi.rlast = 1'b1; axi.rdata = 32'hBAD0_0000 | 32'(i);
                tick();
            end
            axi.rvalid = 1'b1; axi.rdata = base + 32'(i); axi.rlast = (i == n - 1);
            tick();
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
    endtask

    initial begin
        logic [31:0] ca;
        logic [7:0]  cl;
        logic [2:0]  cs;
        logic [1:0]  cb;
        rd_req = 0; burst = 0; addr = 0; size = 0; wr_idle = 1;
        axi.arready = 0; axi.rid = 4'h5; axi.rresp = 2'h2;
        axi.rdata = 0; axi.rlast = 0; axi.rvalid = 0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_rd_rdy", rd_rdy, 1);
        chk("reset_arvalid", axi.arvalid, 0);
        chk("reset_rready", axi.rready, 0);
        chk("reset_unfinish", read_unfinish, 0);
        tick();

        // Line refill, unaligned address
        do_req(1'b1, 32'h1000_0014, 2'd0);
        do_ar(0, ca, cl, cs, cb);
        chk("burst_araddr", ca, 32'h1000_0010);
        chk("burst_arlen", cl, 3);
        chk("burst_arsize", cs, 2);
        chk("burst_arburst", cb, 1);
        do_beats(4, 32'h0000_00A0, 0);
        chk("burst_valid", rd_valid, 1);
        chk("burst_line", rd_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        tick();
        chk("burst_valid_pulse", rd_valid, 0);

        // Single byte uncached access
        do_req(1'b0, 32'hBFD0_0003, 2'd0);
        do_ar(0, ca, cl, cs, cb);
        chk("single_araddr", ca, 32'hBFD0_0003);
        chk("single_arlen", cl, 0);
        chk("single_arsize", cs, 0);
        chk("single_arburst", cb, 0);
        do_beats(1, 32'h0000_00C3, 0);
        chk("single_line", rd_data, {32'hA3, 32'hA2, 32'hA1, 32'hC3});
        tick();

        // Writer busy for 5 cycles, stray requests meanwhile
        wr_idle = 1'b0;
        do_req(1'b1, 32'h2000_0040, 2'd0);
        rd_req = 1'b1; addr = 32'h5555_0000;
        repeat (5) tick();
        chk("wait_arvalid", axi.arvalid, 0);
        chk("wait_unfinish", read_unfinish, 0);
        rd_req = 1'b0;
        wr_idle = 1'b1;
        tick();
        chk("wait_then_ar", axi.arvalid, 1);
        do_ar(0, ca, cl, cs, cb);
        chk("wait_araddr", ca, 32'h2000_0040);
        do_beats(4, 32'h0000_00B0, 0);
        chk("wait_line", rd_data, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        tick();

        // Slow arready and gaps between beats
        do_req(1'b1, 32'h3000_007C, 2'd0);
        do_ar(3, ca, cl, cs, cb);
        chk("slow_araddr", ca, 32'h3000_0070);
        do_beats(4, 32'h0000_00C0, 2);
        chk("slow_line", rd_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        tick();

        // Reset mid-burst after two beats
        do_req(1'b1, 32'h4000_0008, 2'd0);
        do_ar(0, ca, cl, cs, cb);
        axi.rvalid = 1'b1; axi.rlast = 1'b0; axi.rdata = 32'hD0; tick();
        axi.rdata = 32'hD1; tick();
        reset = 1'b1;
        axi.rdata = 32'hEE;
        #1;
        chk("rst_rready", axi.rready, 0);
        chk("rst_unfinish", read_unfinish, 0);
        chk("rst_rd_rdy", rd_rdy, 1);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        axi.rvalid = 1'b0;
        do_req(1'b1, 32'h4000_0008, 2'd0);
        do_ar(0, ca, cl, cs, cb);
        chk("rst_araddr", ca, 32'h4000_0000);
        do_beats(4, 32'h0000_00E0, 1);
        chk("rst_valid", rd_valid, 1);
        chk("rst_line", rd_data, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
